fp_norm_arbiter32: RTL and testbench

- Shares one 8-cycle fpNormalize32 pipeline among NREQ requesters, such as the add, multiply, divide and convert units of the FP32 cluster.
- Grants at most one request per enabled cycle using round-robin arbitration.
- Carries a requester tag alongside each operand through a shadow tag pipeline.
- Routes each normalized result back to its owner, and stalls the whole normalizer (via its ce) when the owner cannot accept the result.

---
 rtl/fp_norm_arbiter32_pkg.sv | 31 +++
 rtl/fp_rr_arbiter.sv | 37 +++
 rtl/fp_norm_arbiter32.sv | 115 +++++++++++
 tb/tb_fp_norm_arbiter32.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_arbiter32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_norm_arbiter32_pkg : FP32 formats and shared-normalizer tag type |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fp_norm_arbiter32_pkg;

  localparam int NORM_LAT = 8;
  localparam int NORM_IDW = 3;

  // Expanded operand: wide exponent and unnormalized mantissa.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
  } FP32X;

  // Normalized IEEE-754 single-precision result.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } FP32N;

  typedef struct packed {
    logic                v;
    logic [NORM_IDW-1:0] id;
  } norm_tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_rr_arbiter : round-robin search from ptr, wrapping modulo N      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fp_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic w_hit;

  // Offset i visits requester (ptr+i) mod N; the first requesting one wins.
  always_comb begin
    w_hit = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (en && !w_hit && req[j] &&
            ((int'(ptr) + i == j) || (int'(ptr) + i == j + N))) begin
          w_hit    = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_norm_arbiter32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_norm_arbiter32 : shares one normalizer pipe among NREQ requesters|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fp_norm_arbiter32
  import fp_norm_arbiter32_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = NORM_LAT,
  parameter int IDW  = NORM_IDW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  FP32X [NREQ-1:0]      req_x,
  input  logic [NREQ-1:0]      req_under,
  output logic                 norm_ce,
  output FP32X                 norm_i,
  output logic                 norm_under_i,
  input  FP32N                 norm_o,
  input  logic                 norm_under_o,
  input  logic                 norm_inexact_o,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output FP32N                 rsp_o,
  output logic                 rsp_under,
  output logic                 rsp_inexact,
  output logic                 busy,
  output logic [3:0]           inflight
);

  logic [LAT:1]    r_tag_v;
  logic [IDW-1:0]  r_tag_id [1:LAT];
  logic [IDW-1:0]  r_rr_ptr;
  logic [3:0]      r_inflight;

  logic            w_stall;
  logic            w_adv;
  logic            w_granted;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gidx;

  // Decode the head tag; the stall is simply a head result its owner refuses.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = r_tag_v[LAT] && (r_tag_id[LAT] == IDW'(k));
    end
  end

  assign w_stall = |(rsp_valid & ~rsp_ready);
  assign w_adv   = ce & ~w_stall & ~rst;
  assign norm_ce = w_adv;

  fp_rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .en    (w_adv),
    .grant (w_grant),
    .idx   (w_gidx)
  );

  assign req_ready = w_grant;
  assign w_granted = |w_grant;

  // Ungranted cycles feed an all-zero bubble into the normalizer.
  always_comb begin
    norm_i       = '0;
    norm_under_i = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        norm_i       = req_x[j];
        norm_under_i = req_under[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_rr_ptr <= '0;
      for (int s = 1; s <= LAT; s++) r_tag_id[s] <= '0;
    end else if (w_adv) begin
      r_tag_v     <= {r_tag_v[LAT-1:1], w_granted};
      r_tag_id[1] <= w_gidx;
      for (int s = 2; s <= LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
      if (w_granted) begin
        r_rr_ptr <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_adv) begin
      if (w_granted && !r_tag_v[LAT])      r_inflight <= r_inflight + 4'd1;
      else if (!w_granted && r_tag_v[LAT]) r_inflight <= r_inflight - 4'd1;
    end
  end

  assign rsp_o       = norm_o;
  assign rsp_under   = norm_under_o;
  assign rsp_inexact = norm_inexact_o;
  assign inflight    = r_inflight;
  assign busy        = (r_inflight != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_arbiter32.sv
`default_nettype none
// Bench for fp_norm_arbiter32 with a behavioural 8-stage normalizer stand-in.
module tb_fp_norm_arbiter32;
  import fp_norm_arbiter32_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  FP32X [NREQ-1:0] req_x;
  logic [NREQ-1:0] req_under;
  logic            norm_ce;
  FP32X            norm_i;
  logic            norm_under_i;
  FP32N            norm_o;
  logic            norm_under_o;
  logic            norm_inexact_o;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  FP32N            rsp_o;
  logic            rsp_under;
  logic            rsp_inexact;
  logic            busy;
  logic [3:0]      inflight;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_norm_arbiter32 #(.NREQ(NREQ), .LAT(LAT), .IDW(3)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_under(req_under),
    .norm_ce(norm_ce), .norm_i(norm_i), .norm_under_i(norm_under_i),
    .norm_o(norm_o), .norm_under_o(norm_under_o), .norm_inexact_o(norm_inexact_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o),
    .rsp_under(rsp_under), .rsp_inexact(rsp_inexact),
    .busy(busy), .inflight(inflight)
  );

  // Normalizer stand-in: no reset, holds when norm_ce is low.
  typedef struct packed { FP32N r; logic u; logic i; } nstage_t;
  nstage_t pipe [1:LAT];
  always @(posedge clk) begin
    if (norm_ce) begin
      pipe[1] <= '{r: '{sign: norm_i.sign, exp: norm_i.exp[7:0], frac: norm_i.mant[46:24]},
                   u: norm_under_i, i: |norm_i.mant[23:0]};
      for (int s = 2; s <= LAT; s++) pipe[s] <= pipe[s-1];
    end
  end
  assign norm_o         = pipe[LAT].r;
  assign norm_under_o   = pipe[LAT].u;
  assign norm_inexact_o = pipe[LAT].i;

  typedef struct {
    logic [3:0] req_valid;
    logic [7:0] base;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp_valid;
    logic [3:0] exp_inflight;
    logic       chk_exp;
    logic [7:0] exp_exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic FP32X mkx(input logic [7:0] e);
    FP32X x;
    x.sign = 1'b0;
    x.exp  = {2'b00, e};
    x.mant = 48'hC000_0000_0000;
    return x;
  endfunction

  task automatic set_x(input logic [7:0] base);
    for (int k = 0; k < NREQ; k++) req_x[k] = mkx(base + 8'(64 * k));
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce = 1'b1;
    req_valid = 4'hF;
    req_under = '0;
    rsp_ready = 4'hF;
    #1;
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    next_cyc();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic run_table(input string nm);
    for (int c = 0; c < tbl.size(); c++) begin
      req_valid = tbl[c].req_valid;
      set_x(tbl[c].base);
      mid();
      chk({nm, "_ready"}, 32'(req_ready), 32'(tbl[c].exp_ready));
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(tbl[c].exp_rsp_valid));
      chk({nm, "_inflight"}, 32'(inflight), 32'(tbl[c].exp_inflight));
      if (tbl[c].chk_exp) chk({nm, "_rsp_exp"}, 32'(rsp_o.exp), 32'(tbl[c].exp_exp));
      next_cyc();
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; req_valid = '0; req_under = '0; rsp_ready = 4'hF;
    set_x(8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Single request from requester 2.
    do_reset();
    req_valid = 4'b0100;
    req_x[2] = mkx(8'h7F);
    req_under = 4'b0100;
    mid();
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_inflight0", 32'(inflight), 0);
    chk("t1_norm_under_i", 32'(norm_under_i), 1);
    next_cyc();
    req_valid = '0;
    req_under = '0;
    for (int c = 1; c <= 9; c++) begin
      mid();
      if (c < 8) begin
        chk("t1_rsp_idle", 32'(rsp_valid), 0);
        chk("t1_inflight_mid", 32'(inflight), 1);
      end else if (c == 8) begin
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t1_rsp_exp", 32'(rsp_o.exp), 32'h7F);
        chk("t1_rsp_frac", 32'(rsp_o.frac), 32'h400000);
        chk("t1_rsp_under", 32'(rsp_under), 1);
        chk("t1_inflight_ret", 32'(inflight), 1);
      end else begin
        chk("t1_rsp_after", 32'(rsp_valid), 0);
        chk("t1_inflight_end", 32'(inflight), 0);
        chk("t1_busy_end", 32'(busy), 0);
      end
      next_cyc();
    end

    // Round-robin under continuous requests.
    do_reset();
    tbl.delete();
    for (int c = 0; c <= 16; c++) begin
      vec_t v;
      v.req_valid     = (c < 8) ? 4'hF : 4'h0;
      v.base          = 8'(c);
      v.exp_ready     = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      v.exp_rsp_valid = (c >= 8 && c < 16) ? 4'(1 << ((c - 8) % 4)) : 4'h0;
      v.exp_inflight  = (c <= 8) ? 4'(c) : 4'(16 - c);
      v.chk_exp       = (c >= 8 && c < 16);
      v.exp_exp       = 8'(64 * ((c - 8) % 4) + (c - 8));
      tbl.push_back(v);
    end
    run_table("t2");

    // Backpressure on requester 1.
    do_reset();
    rsp_ready = 4'b1101;
    for (int k = 0; k < NREQ; k++) req_x[k] = mkx(8'(8'h40 + k));
    for (int c = 0; c <= 16; c++) begin
      req_valid = (c < 3) ? 4'b0111 : ((c >= 9 && c <= 13) ? 4'hF : 4'h0);
      if (c == 14) rsp_ready = 4'hF;
      mid();
      if (c < 3) chk("t3_grant", 32'(req_ready), 32'(1 << c));
      if (c == 8) begin
        chk("t3_rsp0", 32'(rsp_valid), 32'h1);
        chk("t3_rsp0_exp", 32'(rsp_o.exp), 32'h40);
      end
      if (c >= 9 && c <= 13) begin
        chk("t3_stall_norm_ce", 32'(norm_ce), 0);
        chk("t3_stall_ready", 32'(req_ready), 0);
        chk("t3_stall_rsp", 32'(rsp_valid), 32'h2);
        chk("t3_stall_exp", 32'(rsp_o.exp), 32'h41);
        chk("t3_stall_inflight", 32'(inflight), 2);
      end
      if (c == 14) begin
        chk("t3_release_rsp", 32'(rsp_valid), 32'h2);
        chk("t3_release_norm_ce", 32'(norm_ce), 1);
      end
      if (c == 15) begin
        chk("t3_next_rsp", 32'(rsp_valid), 32'h4);
        chk("t3_next_exp", 32'(rsp_o.exp), 32'h42);
      end
      if (c == 16) chk("t3_drained", 32'(inflight), 0);
      next_cyc();
    end

    // Global clock-enable freeze.
    do_reset();
    req_x[3] = mkx(8'h33);
    req_x[0] = mkx(8'h50);
    for (int c = 0; c <= 15; c++) begin
      ce = !(c >= 3 && c <= 5);
      req_valid = (c == 0) ? 4'b1000 : ((c >= 3 && c <= 5) ? 4'b0001 : ((c == 6) ? 4'hF : 4'h0));
      mid();
      if (c == 0) chk("t4_grant3", 32'(req_ready), 32'h8);
      if (c >= 3 && c <= 5) begin
        chk("t4_frozen_norm_ce", 32'(norm_ce), 0);
        chk("t4_frozen_ready", 32'(req_ready), 0);
        chk("t4_frozen_inflight", 32'(inflight), 1);
      end
      if (c == 6) chk("t4_ptr_wrapped", 32'(req_ready), 32'h1);
      if (c >= 1) chk("t4_rsp_valid", 32'(rsp_valid), (c == 11) ? 32'h8 : ((c == 14) ? 32'h1 : 32'h0));
      if (c == 11) chk("t4_rsp_exp3", 32'(rsp_o.exp), 32'h33);
      if (c == 14) chk("t4_rsp_exp0", 32'(rsp_o.exp), 32'h50);
      next_cyc();
    end
    ce = 1'b1;

    // Reset with five slots in flight.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'hF;
      next_cyc();
    end
    req_valid = '0;
    mid();
    chk("t5_inflight5", 32'(inflight), 5);
    rst = 1'b1;
    #1;
    chk("t5_rst_inflight", 32'(inflight), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    next_cyc();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mid();
      chk("t5_no_rsp", 32'(rsp_valid), 0);
      next_cyc();
    end
    req_valid = 4'b0110;
    mid();
    chk("t5_first_grant", 32'(req_ready), 32'h2);
    next_cyc();
    req_valid = '0;

    // Bubble interleave from requester 3.
    do_reset();
    tbl.delete();
    for (int c = 0; c <= 14; c++) begin
      vec_t v;
      int g;
      int r;
      g = int'(c > 0) + int'(c > 2) + int'(c > 5);
      r = int'(c > 8) + int'(c > 10) + int'(c > 13);
      v.req_valid     = (c == 0 || c == 2 || c == 5) ? 4'h8 : 4'h0;
      v.base          = 8'(c);
      v.exp_ready     = v.req_valid;
      v.exp_rsp_valid = (c == 8 || c == 10 || c == 13) ? 4'h8 : 4'h0;
      v.exp_inflight  = 4'(g - r);
      v.chk_exp       = (c == 8 || c == 10 || c == 13);
      v.exp_exp       = 8'(192 + c - 8);
      tbl.push_back(v);
    end
    run_table("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
